// File: rtl/sa_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sa_seq_ctrl
// Purpose  : Job sequencer for the 8x8 systolic-array wrapper. On START it
//            accepts ROWS rows over a valid/ready handshake and writes each
//            one into the wrapper register file. It then holds WRITE high for
//            FLUSH_CYCLES more cycles and drops WRITE for COMPUTE_CYCLES
//            cycles. Completion is signalled with a one-cycle DONE pulse.
// Ports    : CLK, RSTN (async, active-low)
//            START, ABORT          - job control in
//            BUSY, DONE            - job status out
//            IN_VALID/IN_READY/IN_DATA - upstream row stream (16 words of DW)
//            SA_EN, SA_RF_EN, SA_WRITE, SA_IDX, SA_DIN - wrapper control pins
// Revision : 1.0 - initial release
// ============================================================================
module sa_seq_ctrl #(
    parameter int DW             = 16,
    parameter int ROWS           = 8,
    parameter int FLUSH_CYCLES   = 2,
    parameter int COMPUTE_CYCLES = 22
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               START,
    input  logic               ABORT,
    output logic               BUSY,
    output logic               DONE,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [16*DW-1:0]   IN_DATA,
    output logic               SA_EN,
    output logic               SA_RF_EN,
    output logic               SA_WRITE,
    output logic [2:0]         SA_IDX,
    output logic [16*DW-1:0]   SA_DIN
);

    localparam int c_FW = $clog2(FLUSH_CYCLES + 1);
    localparam int c_CW = $clog2(COMPUTE_CYCLES + 1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LOAD    = 3'd1;
    localparam logic [2:0] c_ST_FLUSH   = 3'd2;
    localparam logic [2:0] c_ST_COMPUTE = 3'd3;
    localparam logic [2:0] c_ST_FIN     = 3'd4;

    localparam logic [2:0]      c_LAST_ROW   = 3'(ROWS - 1);
    localparam logic [c_FW-1:0] c_FLUSH_LAST = c_FW'(FLUSH_CYCLES - 1);
    localparam logic [c_CW-1:0] c_COMP_LOAD  = c_CW'(COMPUTE_CYCLES - 1);

    logic [2:0]      r_state;
    logic [2:0]      w_next_state;
    logic [2:0]      r_row_cnt;
    logic [c_FW-1:0] r_flush_cnt;
    logic [c_CW-1:0] r_comp_cnt;
    logic            w_abort;
    logic            w_accept;
    logic            w_last_row;
    logic            w_flush_done;

    // ABORT only matters once a job is running; it also vetoes a handshake
    // landing on the same edge so that row is neither stored nor counted.
    assign w_abort      = ABORT && (r_state != c_ST_IDLE);
    assign w_accept     = IN_VALID && IN_READY && !w_abort;
    assign w_last_row   = (r_row_cnt == c_LAST_ROW);
    assign w_flush_done = (r_flush_cnt == c_FLUSH_LAST);

    // State register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (w_abort) begin
            w_next_state = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:    if (START) w_next_state = c_ST_LOAD;
                c_ST_LOAD:    if (w_accept && w_last_row) w_next_state = c_ST_FLUSH;
                c_ST_FLUSH:   if (w_flush_done) w_next_state = c_ST_COMPUTE;
                c_ST_COMPUTE: if (r_comp_cnt == '0) w_next_state = c_ST_FIN;
                c_ST_FIN:     w_next_state = c_ST_IDLE;
                default:      w_next_state = c_ST_IDLE;
            endcase
        end
    end

    // Output decode: all handshake/control pins depend on state only
    always_comb begin
        IN_READY = 1'b0;
        BUSY     = (r_state != c_ST_IDLE);
        DONE     = 1'b0;
        SA_EN    = 1'b0;
        SA_RF_EN = 1'b0;
        SA_WRITE = 1'b1;
        case (r_state)
            c_ST_LOAD: begin
                IN_READY = 1'b1;
                SA_EN    = 1'b1;
                SA_RF_EN = 1'b1;
            end
            c_ST_FLUSH: begin
                SA_EN    = 1'b1;
                SA_RF_EN = 1'b1;
            end
            c_ST_COMPUTE: begin
                SA_EN    = 1'b1;
                SA_RF_EN = 1'b1;
                SA_WRITE = 1'b0;
            end
            c_ST_FIN: begin
                DONE = 1'b1;
            end
            default: ;
        endcase
    end

    // Counters and the registered row presented to the wrapper. SA_DIN and
    // SA_IDX keep the last accepted row through gaps, flush and compute;
    // rewriting the same RF row during a gap is harmless.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_row_cnt   <= '0;
            r_flush_cnt <= '0;
            r_comp_cnt  <= '0;
            SA_IDX      <= '0;
            SA_DIN      <= '0;
        end else if (w_abort) begin
            r_row_cnt   <= '0;
            r_flush_cnt <= '0;
            r_comp_cnt  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (START) r_row_cnt <= '0;
                end
                c_ST_LOAD: begin
                    if (w_accept) begin
                        SA_DIN <= IN_DATA;
                        SA_IDX <= r_row_cnt;
                        if (w_last_row) begin
                            r_row_cnt   <= '0;
                            r_flush_cnt <= '0;
                        end else begin
                            r_row_cnt <= r_row_cnt + 3'd1;
                        end
                    end
                end
                c_ST_FLUSH: begin
                    if (w_flush_done) begin
                        r_flush_cnt <= '0;
                        r_comp_cnt  <= c_COMP_LOAD;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + c_FW'(1);
                    end
                end
                c_ST_COMPUTE: begin
                    if (r_comp_cnt != '0) r_comp_cnt <= r_comp_cnt - c_CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
